// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream arbiter library.
// rr_next is a pure round-robin search; callers fold it into logic with a constant n.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Upper bound on requesters the generic search can scan.
  localparam int unsigned ARB_MAX_STREAMS = 32;

  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set req bit after last, wrapping modulo n; returns last%n when none is set.
  function automatic int unsigned rr_next(input logic [ARB_MAX_STREAMS-1:0] req,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned idx;
    int unsigned cand;
    logic        hit;
    idx = last % n;
    hit = 1'b0;
    for (int unsigned k = 1; k <= ARB_MAX_STREAMS; k++) begin
      cand = (last + k) % n;
      if (k <= n && !hit && req[cand]) begin
        idx = cand;
        hit = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first requester after 'last', wrapping modulo NUM_STREAMS.
// The previous winner is still eligible when it is the only requester.
module rr_priority_select
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = 2,
  parameter int unsigned IDX_W       = arb_idx_w(NUM_STREAMS)
) (
  input  logic [NUM_STREAMS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic                   found,
  output logic [IDX_W-1:0]       idx
);

  logic [ARB_MAX_STREAMS-1:0] req_ext;

  always_comb begin
    req_ext                    = '0;
    req_ext[NUM_STREAMS-1:0]   = req;
    found                      = |req;
    idx                        = IDX_W'(rr_next(req_ext, 32'(last), NUM_STREAMS));
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter: one bubble to arbitrate, grant held through tlast.
// Define AXIS_ARB_SRC_ID_EN to add axis_o_tid carrying the granted stream index.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned AXIS_BYTES     = 1,
  parameter int unsigned AXIS_USER_BITS = 1,
  parameter int unsigned NUM_STREAMS    = 2
) (
  input  logic                                    clk,
  input  logic                                    sresetn,
  input  logic [NUM_STREAMS-1:0]                  axis_i_tvalid,
  output logic [NUM_STREAMS-1:0]                  axis_i_tready,
  input  logic [NUM_STREAMS-1:0]                  axis_i_tlast,
  input  logic [NUM_STREAMS*AXIS_BYTES-1:0]       axis_i_tkeep,
  input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0]     axis_i_tdata,
  input  logic [NUM_STREAMS*AXIS_USER_BITS-1:0]   axis_i_tuser,
  output logic                                    axis_o_tvalid,
  input  logic                                    axis_o_tready,
  output logic                                    axis_o_tlast,
  output logic [AXIS_BYTES-1:0]                   axis_o_tkeep,
  output logic [AXIS_BYTES*8-1:0]                 axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]               axis_o_tuser
`ifdef AXIS_ARB_SRC_ID_EN
  ,
  output logic [arb_idx_w(NUM_STREAMS)-1:0]       axis_o_tid
`endif
);

  localparam int unsigned IDX_W = arb_idx_w(NUM_STREAMS);
  localparam int unsigned DW    = AXIS_BYTES * 8;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] last_grant, last_grant_nxt;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             locked;
  logic             pkt_done;

  rr_priority_select #(
    .NUM_STREAMS (NUM_STREAMS),
    .IDX_W       (IDX_W)
  ) u_sel (
    .req   (axis_i_tvalid),
    .last  (last_grant),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Gating with sresetn keeps the bus quiet during the reset cycle itself.
  assign locked   = (state == ARB_LOCKED) && sresetn;
  assign pkt_done = axis_o_tvalid && axis_o_tready && axis_o_tlast;

  always_comb begin
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tkeep  = '0;
    axis_o_tdata  = '0;
    axis_o_tuser  = '0;
    axis_i_tready = '0;
    if (locked) begin
      axis_o_tvalid        = axis_i_tvalid[grant];
      axis_o_tlast         = axis_i_tlast[grant];
      axis_o_tkeep         = axis_i_tkeep[int'(grant)*AXIS_BYTES +: AXIS_BYTES];
      axis_o_tdata         = axis_i_tdata[int'(grant)*DW +: DW];
      axis_o_tuser         = axis_i_tuser[int'(grant)*AXIS_USER_BITS +: AXIS_USER_BITS];
      axis_i_tready[grant] = axis_o_tready;
    end
  end

`ifdef AXIS_ARB_SRC_ID_EN
  assign axis_o_tid = axis_o_tvalid ? grant : '0;
`endif

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    if (state == ARB_IDLE) begin
      if (sel_found) begin
        grant_nxt = sel_idx;
        state_nxt = ARB_LOCKED;
      end
    end else if (pkt_done) begin
      last_grant_nxt = grant;
      state_nxt      = ARB_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_STREAMS - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter with three streams; expected beat order is hand-derived.
module tb_axis_rr_arbiter;

  localparam int NS = 3;
  localparam int NB = 1;
  localparam int NU = 1;

  logic clk = 1'b0;
  logic sresetn;
  logic [NS-1:0]      i_tvalid, i_tready, i_tlast;
  logic [NS*NB-1:0]   i_tkeep;
  logic [NS*NB*8-1:0] i_tdata;
  logic [NS*NU-1:0]   i_tuser;
  logic               o_tvalid, o_tready, o_tlast;
  logic [NB-1:0]      o_tkeep;
  logic [NB*8-1:0]    o_tdata;
  logic [NU-1:0]      o_tuser;
`ifdef AXIS_ARB_SRC_ID_EN
  logic [1:0]         o_tid;
`endif

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .AXIS_BYTES     (NB),
    .AXIS_USER_BITS (NU),
    .NUM_STREAMS    (NS)
  ) dut (
    .clk           (clk),
    .sresetn       (sresetn),
    .axis_i_tvalid (i_tvalid),
    .axis_i_tready (i_tready),
    .axis_i_tlast  (i_tlast),
    .axis_i_tkeep  (i_tkeep),
    .axis_i_tdata  (i_tdata),
    .axis_i_tuser  (i_tuser),
    .axis_o_tvalid (o_tvalid),
    .axis_o_tready (o_tready),
    .axis_o_tlast  (o_tlast),
    .axis_o_tkeep  (o_tkeep),
    .axis_o_tdata  (o_tdata),
    .axis_o_tuser  (o_tuser)
`ifdef AXIS_ARB_SRC_ID_EN
    ,
    .axis_o_tid    (o_tid)
`endif
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       keep;
    logic       user;
    logic       last;
  } beat_t;

  beat_t sq[NS][$];
  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    hs_cnt  = 0;
  logic  rdy_pat_on = 1'b0;
  logic [15:0] rdy_pat = 16'hB2E5;
  int    pat_idx = 0;

  function automatic beat_t mk(input int s, input int pkt, input int n, input int b);
    beat_t t;
    t.id   = s[1:0];
    t.data = {s[1:0], pkt[2:0], b[2:0]};
    t.keep = pkt[0] ^ b[0];
    t.user = b[1];
    t.last = (b == n - 1);
    return t;
  endfunction

  task automatic push_src(input int s, input int pkt, input int n);
    for (int b = 0; b < n; b++) sq[s].push_back(mk(s, pkt, n, b));
  endtask

  task automatic push_exp(input int s, input int pkt, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back(mk(s, pkt, n, b));
  endtask

  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      beat_t t;
      if (sq[s].size() > 0) begin
        t = sq[s][0];
        i_tvalid[s]         = 1'b1;
        i_tdata[s*8 +: 8]   = t.data;
        i_tkeep[s]          = t.keep;
        i_tuser[s]          = t.user;
        i_tlast[s]          = t.last;
      end else begin
        i_tvalid[s]         = 1'b0;
        i_tdata[s*8 +: 8]   = 8'h00;
        i_tkeep[s]          = 1'b0;
        i_tuser[s]          = 1'b0;
        i_tlast[s]          = 1'b0;
      end
    end
  endtask

  // One clock: sample source handshakes mid-cycle, then advance sources after the edge.
  task automatic tick();
    logic [NS-1:0] hs;
    @(negedge clk);
    hs = i_tvalid & i_tready;
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++)
      if (hs[s] && sq[s].size() > 0) void'(sq[s].pop_front());
    if (rdy_pat_on) begin
      o_tready = rdy_pat[pat_idx];
      pat_idx  = (pat_idx + 1) % 16;
    end
    drive();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic bit srcs_empty();
    for (int s = 0; s < NS; s++) if (sq[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || !srcs_empty()) && c < budget) begin
      tick();
      c++;
    end
    n_tests++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats still expected after %0d cycles, expected 0", name, exp_q.size(), budget);
    end
    repeat (2) tick();
  endtask

  task automatic wait_hs(input string name, input int base, input int budget);
    int c = 0;
    while (hs_cnt - base < 1 && c < budget) begin
      tick();
      c++;
    end
    check(name, (hs_cnt - base >= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Monitor: scoreboard pops on every output handshake; also checks stall hold and post-packet bubble.
  initial begin
    beat_t got, want, held;
    bit    stall_pend = 1'b0;
    bit    after_last = 1'b0;
    forever begin
      @(negedge clk);
      if (sresetn !== 1'b1) begin
        stall_pend = 1'b0;
        after_last = 1'b0;
      end else begin
`ifdef AXIS_ARB_SRC_ID_EN
        got.id = o_tid;
        if (!o_tvalid) check("tid_idle", 32'(o_tid), 32'd0);
`else
        got.id = o_tdata[7:6];
`endif
        got.data = o_tdata;
        got.keep = o_tkeep[0];
        got.user = o_tuser[0];
        got.last = o_tlast;
        if (after_last) check("bubble", 32'(o_tvalid), 32'd0);
        after_last = 1'b0;
        if (stall_pend) check("stall_hold", {o_tvalid, 18'd0, got}, {1'b1, 18'd0, held});
        stall_pend = 1'b0;
        if (o_tvalid && !o_tready) begin
          stall_pend = 1'b1;
          held       = got;
        end
        if (o_tvalid && o_tready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", got);
          end else begin
            want = exp_q.pop_front();
            check("beat", 32'(got), 32'(want));
          end
          if (o_tlast) after_last = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    sresetn  = 1'b0;
    o_tready = 1'b1;
    i_tvalid = '0; i_tlast = '0; i_tkeep = '0; i_tdata = '0; i_tuser = '0;
    repeat (3) begin
      tick();
      check("rst_vld", 32'(o_tvalid), 32'd0);
      check("rst_rdy", 32'(i_tready), 32'd0);
    end
    sresetn = 1'b1;

    // Idle with no requests
    repeat (10) begin
      tick();
      check("idle_vld", 32'(o_tvalid), 32'd0);
      check("idle_rdy", 32'(i_tready), 32'd0);
    end

    // All three streams, two 2-beat packets each: strict 0,1,2 rotation
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++) push_src(s, p, 2);
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++) push_exp(s, p, 2);
    drive();
    wait_drain("rotate", 100);

    // Lone stream 2, back-to-back single-beat packets: one beat per two cycles
    for (int p = 0; p < 4; p++) begin
      push_src(2, p, 1);
      push_exp(2, p, 1);
    end
    drive();
    base = hs_cnt;
    repeat (8) tick();
    check("single_rate", 32'(hs_cnt - base), 32'd4);
    wait_drain("single", 50);

    // Stream 0 arrives mid-packet of stream 1 and must wait for its tlast
    push_src(1, 1, 4);
    push_exp(1, 1, 4);
    drive();
    wait_hs("hold_first", hs_cnt, 20);
    push_src(0, 1, 2);
    push_exp(0, 1, 2);
    drive();
    #1;
    check("hold_rdy0", 32'(i_tready[0]), 32'd0);
    wait_drain("hold", 100);

    // 5-beat packet under a toggling output ready
    rdy_pat_on = 1'b1;
    push_src(0, 2, 5);
    push_exp(0, 2, 5);
    drive();
    wait_drain("stall", 200);
    rdy_pat_on = 1'b0;
    o_tready   = 1'b1;
    tick();

    // Reset while beat 2 of a stream-1 packet is on the bus
    push_src(1, 2, 4);
    exp_q.push_back(mk(1, 2, 4, 0));
    drive();
    wait_hs("rst_mid_first", hs_cnt, 20);
    #1;
    check("rst_mid_inflight", 32'(o_tvalid), 32'd1);
    sresetn = 1'b0;
    #1;
    check("rst_mid_vld", 32'(o_tvalid), 32'd0);
    check("rst_mid_rdy", 32'(i_tready), 32'd0);
    tick();
    sresetn = 1'b1;
    for (int s = 0; s < NS; s++) sq[s].delete();
    check("rst_mid_leftover", 32'(exp_q.size()), 32'd0);
    push_src(1, 3, 2);
    push_src(0, 3, 2);
    drive();
    #1;
    check("post_rst_vld", 32'(o_tvalid), 32'd0);
    check("post_rst_rdy", 32'(i_tready), 32'd0);
    push_exp(0, 3, 2);
    push_exp(1, 3, 2);
    wait_drain("post_rst", 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
